// File: rtl/event_filter_stream_pkg.sv
// Shared event type, polarity bit indices and pass-mode encodings for the
// event filter stream.
package event_filter_pkg;

   localparam int X_W_DEF = 8;
   localparam int Y_W_DEF = 8;
   localparam int T_W_DEF = 16;

   // Bit positions inside pol_mask
   localparam int POL_OFF = 0;
   localparam int POL_ON  = 1;

   localparam logic [1:0] PASS_NONE = 2'b00;
   localparam logic [1:0] PASS_OFF  = 2'b01;
   localparam logic [1:0] PASS_ON   = 2'b10;
   localparam logic [1:0] PASS_ALL  = 2'b11;

   typedef struct packed {
      logic [X_W_DEF-1:0] x;
      logic [Y_W_DEF-1:0] y;
      logic [T_W_DEF-1:0] t;
      logic               p;
   } event_t;

endpackage

// File: rtl/event_filter_stream_fifo.sv
// Small register FIFO: power-of-two depth, wrapping pointers, and an
// occupancy counter that tells full apart from empty.
module event_fifo #(
   parameter  int W     = 33,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [W-1:0]     din_i,
   input  logic             pop_i,
   output logic [W-1:0]     dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LVL_W-1:0] level_o
);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             do_push, do_pop;

   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign empty_o = (level_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_ptr_q];
   assign level_o = level_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      level_d = level_q + LVL_W'(1);
      else if (!do_push && do_pop) level_d = level_q - LVL_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) mem_q[wr_ptr_q] <= din_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

endmodule

// File: rtl/event_filter_stream.sv
// Address-event filter: polarity mask plus global refractory gap, passing
// events queued toward the packer, dropped events counted.
module event_filter_stream
   import event_filter_pkg::*;
#(
   parameter int X_W    = 8,
   parameter int Y_W    = 8,
   parameter int T_W    = 16,
   parameter int DEPTH  = 4,
   parameter int DROP_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [X_W-1:0]           in_x,
   input  logic [Y_W-1:0]           in_y,
   input  logic [T_W-1:0]           in_t,
   input  logic                     in_p,
   input  logic                     en,
   input  logic [1:0]               pol_mask,
   input  logic [T_W-1:0]           min_dt,
   input  logic                     cnt_clr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [X_W-1:0]           out_x,
   output logic [Y_W-1:0]           out_y,
   output logic [T_W-1:0]           out_t,
   output logic                     out_p,
   output logic [DROP_W-1:0]        drop_cnt,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int D_W = X_W + Y_W + T_W + 1;

   // Handshake: a transfer happens on a rising edge where valid && ready.
   // Valid never waits on ready; ready depends only on registered state, so
   // there is no combinational path from any input to any output.
   logic             full, empty, accept, pol_ok, dt_ok, pass, push, drop;
   logic [T_W-1:0]   dt;
   logic [T_W-1:0]   last_t_q, last_t_d;
   logic             have_last_q, have_last_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

   assign in_ready = !full;
   assign accept   = in_valid && in_ready;
   assign pol_ok   = in_p ? pol_mask[POL_ON] : pol_mask[POL_OFF];
   assign dt       = in_t - last_t_q;   // modular gap across timestamp wrap
   assign dt_ok    = (min_dt == '0) || !have_last_q || (dt >= min_dt);
   assign pass     = !en || (pol_ok && dt_ok);
   assign push     = accept && pass;
   assign drop     = accept && !pass;

   always_comb begin
      last_t_d    = last_t_q;
      have_last_d = have_last_q;
      drop_cnt_d  = drop_cnt_q;
      // Bypassed events must not disturb the refractory reference.
      if (push && en) begin
         last_t_d    = in_t;
         have_last_d = 1'b1;
      end
      if (cnt_clr)                          drop_cnt_d = '0;
      else if (drop && (drop_cnt_q != '1))  drop_cnt_d = drop_cnt_q + DROP_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_t_q    <= '0;
         have_last_q <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         last_t_q    <= last_t_d;
         have_last_q <= have_last_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   event_fifo #(.W(D_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .din_i   ({in_x, in_y, in_t, in_p}),
      .pop_i   (out_ready),
      .dout_o  ({out_x, out_y, out_t, out_p}),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );

   assign out_valid = !empty;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/event_filter_stream.md
Name: event_filter_stream

Overview:
- Parametrised successor to the 2-bit event filter for the event-camera path.
- Accepts address-event packets {x, y, t, p} over a valid/ready stream.
- Applies a programmable polarity mask and a global refractory (minimum timestamp gap) filter, then queues passing events in a small FIFO toward the downstream packer.
- Counts discarded events for host visibility.

Parameters:
- X_W, 8, x address width
- Y_W, 8, y address width
- T_W, 16, timestamp width (wraps modulo 2^T_W)
- DEPTH, 4, FIFO entries (power of two, >=2)
- DROP_W, 16, drop counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input event valid
- in_ready  out  1  input can be accepted
- in_x  in  X_W  event x
- in_y  in  Y_W  event y
- in_t  in  T_W  event timestamp
- in_p  in  1  polarity (1 = ON, 0 = OFF)
- en  in  1  filter enable; 0 = bypass (all events pass)
- pol_mask  in  2  bit0 passes OFF, bit1 passes ON
- min_dt  in  T_W  refractory gap; 0 disables refractory check
- cnt_clr  in  1  synchronous clear of drop_cnt
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accepts head
- out_x/out_y/out_t  out  X_W/Y_W/T_W  head event fields
- out_p  out  1  head polarity
- drop_cnt  out  DROP_W  saturating count of filtered events
- level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty; out_valid=0, level=0, drop_cnt=0.
  - out_* data fields = 0.
  - have_last=0, last_t=0.
- Accept:
  - in_ready = (level != DEPTH), combinational from registered state.
  - An event is accepted when in_valid && in_ready.
- Filter decision (combinational on accepted event):
  - pol_ok = pol_mask[in_p].
  - dt = (in_t - last_t) mod 2^T_W.
  - dt_ok = (min_dt==0) || !have_last || (dt >= min_dt).
  - pass = !en || (pol_ok && dt_ok).
- Pass:
  - Event is written to the FIFO tail.
  - last_t <= in_t and have_last <= 1, but only when en=1; bypass does not update refractory state.
- Drop:
  - Event is consumed (no backpressure); nothing is written.
  - drop_cnt increments, saturating at 2^DROP_W-1.
  - last_t is unchanged.
- Latency: passing event appears at out_valid one cycle after acceptance when the FIFO was empty; no combinational in-to-out path.
- Output:
  - out_valid = (level != 0); out_* always reflect the head entry.
  - Head pops on out_valid && out_ready.
  - Head data must be held stable while out_valid && !out_ready.
- Simultaneous push and pop: level unchanged; legal at any non-full occupancy.
- Full: in_ready=0, even if out_ready=1 in the same cycle. No push-through-when-full.
- Empty with out_ready=1: no effect.
- Pointer wrap: pointers run modulo DEPTH; level distinguishes full from empty.
- cnt_clr with a simultaneous drop: clear wins, so drop_cnt=0.
- Configuration changes: changes to en, pol_mask and min_dt take effect on the next accepted event; queued events are never re-filtered.
- Timestamp wrap: modular subtraction, e.g. last_t=0xFFF0, in_t=0x0005 gives dt=0x0015.
- Reset mid-operation: all queued events are lost; refractory state is cleared.

Decomposition:
- Package event_filter_pkg:
  - event struct type (x, y, t, p) built from the width parameters' defaults.
  - POL_OFF/POL_ON mask bit indices.
  - Mode constants PASS_NONE=2'b00, PASS_OFF=2'b01, PASS_ON=2'b10, PASS_ALL=2'b11.
- One sub-module event_fifo:
  - Parametrised by data width and DEPTH.
  - Handles push/pop, level and pointers.
  - Top level keeps the filter logic, refractory state and drop counter.

Test Plan:
- Reset then idle: after rst_n release, out_valid=0, in_ready=1, level=0, drop_cnt=0; assert rst_n low mid-queue with 3 entries, expect level=0 immediately.
- Polarity: en=1, pol_mask=2'b10, min_dt=0, send p=1,0,1,0 -> 2 events out (both p=1, in order), drop_cnt=2.
- Refractory with wrap: min_dt=0x0010, pol_mask=2'b11:
  - send t=0xFFF8 -> pass
  - t=0x0002 (dt=0x000A) -> dropped
  - t=0x0008 (dt=0x0010) -> pass
  - expected drop_cnt=1.
- Backpressure/full: DEPTH=4, out_ready=0, send 6 events -> in_ready falls after 4th acceptance, level=4. Raise out_ready -> events drain in order, with data stable while stalled.
- Bypass and simultaneity:
  - en=0, pol_mask=2'b00 -> all events pass; last_t unchanged.
  - Push and pop in the same cycle at level=2 -> level stays 2.
- Counter: force 2^DROP_W-1 drops (DROP_W=4 build) -> drop_cnt holds at 15. cnt_clr concurrent with a drop -> drop_cnt=0.
